alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 alu_op  input  4  operation code produced by the ALU control decoder.
REQ-007 op_a  input  WIDTH  first operand (rs1).
REQ-008 op_b  input  WIDTH  second operand (rs2 or immediate).
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 result  output  WIDTH  operation result.
REQ-012 zero  output  1  result equals 0; used for branch compare.
REQ-013 illegal  output  1  accepted alu_op was not a defined code.

Function
REQ-014 Request accepted on an edge where in_valid and in_ready are both 1; alu_op, op_a, op_b captured at that edge.
REQ-015 States: IDLE, ITER, DONE; in_ready = 1 only in IDLE.
REQ-016 Single-cycle codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 shl logical, 0110 shr logical, 0111 SLT signed (result 1 or 0).
REQ-017 Shift amount = op_b[log2(WIDTH)-1:0]; upper op_b bits ignored.
REQ-018 Add/sub wrap modulo 2^WIDTH; no carry or overflow output.
REQ-019 Single-cycle op: IDLE -> DONE at acceptance edge; out_valid high in the cycle after acceptance.
REQ-020 Iterative codes: 1000 MUL (low WIDTH bits), 1001 MULHU (high WIDTH bits, unsigned), 1010 DIVU, 1011 REMU.
REQ-021 Iterative op: IDLE -> ITER at acceptance; one shift-add (multiply) or restoring-subtract (divide) step per cycle; exactly WIDTH steps; after the final step -> DONE; out_valid first high WIDTH+1 cycles after acceptance cycle.
REQ-022 Iteration counter width log2(WIDTH)+1; counts 0..WIDTH-1, no wrap past WIDTH.
REQ-023 DIVU with op_b = 0: result all ones; REMU with op_b = 0: result = op_a; still takes WIDTH+1 cycles.
REQ-024 Any other code (incl. 1111): IDLE -> DONE, result 0, illegal 1, zero 1.
REQ-025 DONE: result, zero, illegal held stable while out_valid = 1 and out_ready = 0.
REQ-026 DONE with out_ready = 1 -> IDLE at that edge; out_valid low next cycle; no new acceptance in the same edge (in_ready is 0 in DONE).
REQ-027 in_valid while not in_ready: ignored, no side effect; requester holds request.
REQ-028 alu_op/op_a/op_b changes after acceptance do not affect the in-flight result.
REQ-029 zero = (result == 0) for every completed op.
REQ-030 illegal = 0 for every defined code.

Reset
REQ-031 rst = 1 forces state IDLE immediately, regardless of clock, including mid-iteration (in-flight op discarded).
REQ-032 Reset values: in_ready 1 once state is IDLE, out_valid 0, result 0, zero 0, illegal 0, counter 0, internal accumulators 0.
REQ-033 First acceptance possible on the first rising edge after rst deasserts.

Structure
REQ-034 ALU op-code constants (the twelve codes above plus 1111 invalid) live in shared package alu_defs, used by the decoder and this block.
REQ-035 State encoding constants for IDLE/ITER/DONE live in alu_defs.
REQ-036 Iterative datapath is sub-module alu_muldiv_iter (start, mode, operands, done, result); single-cycle ops stay in alu_exec.
REQ-037 alu_muldiv_iter holds a 2*WIDTH accumulator shared by multiply and divide; no hardware multiplier or divider operator.

Verification
REQ-038 Reset then alu_op 0001, op_a 5, op_b 5 -> out_valid next cycle, result 0, zero 1, illegal 0.
REQ-039 alu_op 0111, op_a 0xFFFFFFFF, op_b 1 -> result 1; alu_op 0110 op_a 0x80000000 op_b 0x21 -> result 0x40000000.
REQ-040 alu_op 1001, op_a 0xFFFFFFFF, op_b 0xFFFFFFFF -> out_valid exactly 33 cycles after acceptance, result 0xFFFFFFFE; same with 1000 -> result 1.
REQ-041 alu_op 1010 op_a 100 op_b 7 -> 14; 1011 -> 2; op_b 0 -> 0xFFFFFFFF and 100 respectively.
REQ-042 DIVU accepted, rst pulsed at iteration 10 -> out_valid 0, in_ready 1 after reset; new add 2+3 -> 5 one cycle later.
REQ-043 alu_op 1111 with out_ready held 0 for 5 cycles -> result 0, illegal 1 stable, in_ready 0 throughout; out_ready 1 -> IDLE next cycle.

Source files
------------

// File: rtl/alu_defs.sv
// Shared ALU definitions: operation codes, execution-unit state encoding and
// a small op-class helper used by the control decoder and the execute stage.
package alu_defs;

    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_SUB     = 4'b0001;
    localparam logic [3:0] ALU_AND     = 4'b0010;
    localparam logic [3:0] ALU_OR      = 4'b0011;
    localparam logic [3:0] ALU_XOR     = 4'b0100;
    localparam logic [3:0] ALU_SHL     = 4'b0101;
    localparam logic [3:0] ALU_SHR     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_MUL     = 4'b1000;
    localparam logic [3:0] ALU_MULHU   = 4'b1001;
    localparam logic [3:0] ALU_DIVU    = 4'b1010;
    localparam logic [3:0] ALU_REMU    = 4'b1011;
    localparam logic [3:0] ALU_INVALID = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Codes 1000..1011 run on the iterative multiply/divide unit.
    function automatic logic is_iter_op(input logic [3:0] op);
        return (op[3:2] == 2'b10);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply / divide: one shift-add or restoring-subtract
// step per cycle over a shared 2*WIDTH accumulator, WIDTH steps per operation.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic               r_busy;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [1:0]         r_mode;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_last;

    // mode[1]=0 multiply (multiplier in acc low half, product shifts in from top);
    // mode[1]=1 divide (remainder high half, quotient bits shift into low half).
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
        w_div_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_b};
        if (!r_mode[1]) begin
            w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
        end else if (w_div_trial[WIDTH]) begin
            w_acc_next = {r_acc[2*WIDTH-2:0], 1'b0};
        end else begin
            w_acc_next = {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end
    end

    assign w_last = r_busy && (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_b    <= '0;
            r_mode <= '0;
        end else if (i_start && !r_busy) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_acc  <= {{WIDTH{1'b0}}, i_a};
            r_b    <= i_b;
            r_mode <= i_mode;
        end else if (r_busy) begin
            r_acc <= w_acc_next;
            if (w_last) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // A zero divisor never fails a trial subtract, so DIVU yields all ones and
    // REMU yields the dividend without special casing.
    assign o_done   = w_last;
    assign o_result = r_mode[0] ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: single-cycle logic/arith/shift ops computed at acceptance,
// multiply/divide handed to alu_muldiv_iter; valid/ready handshake on both sides.
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    import alu_defs::*;

    localparam int SHW = $clog2(WIDTH);

    alu_state_e       r_state;
    alu_state_e       w_next;
    logic [WIDTH-1:0] r_result;
    logic             r_illegal;
    logic             r_is_iter;

    logic             w_accept;
    logic             w_start;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_result;

    function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [WIDTH-1:0]        res;
        sa  = a;
        sb  = b;
        res = '0;
        case (op)
            ALU_ADD: res = a + b;
            ALU_SUB: res = a - b;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_XOR: res = a ^ b;
            ALU_SHL: res = a << b[SHW-1:0];
            ALU_SHR: res = a >> b[SHW-1:0];
            ALU_SLT: res = {{(WIDTH-1){1'b0}}, (sa < sb)};
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic op_illegal(input logic [3:0] op);
        logic ill;
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_SLT,
            ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU: ill = 1'b0;
            ALU_INVALID: ill = 1'b1;
            default:     ill = 1'b1;
        endcase
        return ill;
    endfunction

    assign w_accept = in_valid && in_ready;
    assign w_start  = w_accept && is_iter_op(alu_op);

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_mode   (alu_op[1:0]),
        .i_a      (op_a),
        .i_b      (op_b),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_next = is_iter_op(alu_op) ? ST_ITER : ST_DONE;
            ST_ITER: if (w_md_done) w_next = ST_DONE;
            ST_DONE: if (out_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
    end

    // Operands are consumed at acceptance, so later input changes cannot leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result  <= '0;
            r_illegal <= 1'b0;
            r_is_iter <= 1'b0;
        end else if (w_accept) begin
            r_result  <= alu_single(alu_op, op_a, op_b);
            r_illegal <= op_illegal(alu_op);
            r_is_iter <= is_iter_op(alu_op);
        end
    end

    assign result  = r_is_iter ? w_md_result : r_result;
    assign zero    = out_valid && (result == '0);
    assign illegal = out_valid && r_illegal;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed vectors push expected results, a
// negedge monitor checks latency and pops/compares on each output handshake.
module tb_alu_exec;
    import alu_defs::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit seen     = 1'b0;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic         z;
        logic         il;
        int           lat;
        int           acc;
    } exp_t;

    exp_t q[$];

    alu_exec #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic issue(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_res,
                         input logic exp_il, input int lat);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        in_valid = 1'b1;
        alu_op   = op;
        op_a     = a;
        op_b     = b;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk({nm, "_accept_timeout"}, 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            e.name = nm;
            e.res  = exp_res;
            e.z    = (exp_res == '0);
            e.il   = exp_il;
            e.lat  = lat;
            e.acc  = cyc;
            q.push_back(e);
            in_valid = 1'b0;
            alu_op   = 4'($urandom);
            op_a     = $urandom;
            op_b     = $urandom;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got out_valid=1 expected no pending op");
                end else begin
                    chk({q[0].name, "_latency"}, 32'(cyc - q[0].acc + 1), 32'(q[0].lat));
                end
            end
            if (out_ready && q.size() != 0) begin
                e = q.pop_front();
                chk({e.name, "_result"}, result, e.res);
                chk({e.name, "_zero"}, 32'(zero), 32'(e.z));
                chk({e.name, "_illegal"}, 32'(illegal), 32'(e.il));
                seen = 1'b0;
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        alu_op    = '0;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        rst = 1'b0;

        issue("sub_5_5",    ALU_SUB,   32'd5,          32'd5,          32'd0,          1'b0, 1);
        issue("slt_m1_1",   ALU_SLT,   32'hFFFFFFFF,   32'd1,          32'd1,          1'b0, 1);
        issue("slt_1_m1",   ALU_SLT,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 1);
        issue("shr_33",     ALU_SHR,   32'h80000000,   32'h21,         32'h40000000,   1'b0, 1);
        issue("shl_31",     ALU_SHL,   32'd1,          32'h1F,         32'h80000000,   1'b0, 1);
        issue("shl_36",     ALU_SHL,   32'd3,          32'h24,         32'h30,         1'b0, 1);
        issue("add_wrap",   ALU_ADD,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 1);
        issue("and",        ALU_AND,   32'hF0F0F0F0,   32'h0FF00FF0,   32'h00F000F0,   1'b0, 1);
        issue("or",         ALU_OR,    32'hF0F0F0F0,   32'h0F0F0000,   32'hFFFFF0F0,   1'b0, 1);
        issue("xor",        ALU_XOR,   32'hAAAA5555,   32'hFFFF0000,   32'h55555555,   1'b0, 1);
        issue("mulhu_max",  ALU_MULHU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   1'b0, 33);
        issue("mul_max",    ALU_MUL,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          1'b0, 33);
        issue("mul_x10",    ALU_MUL,   32'h12345678,   32'h10,         32'h23456780,   1'b0, 33);
        issue("mulhu_x4",   ALU_MULHU, 32'h80000000,   32'd4,          32'd2,          1'b0, 33);
        issue("divu_100_7", ALU_DIVU,  32'd100,        32'd7,          32'd14,         1'b0, 33);
        issue("remu_100_7", ALU_REMU,  32'd100,        32'd7,          32'd2,          1'b0, 33);
        issue("divu_by0",   ALU_DIVU,  32'd100,        32'd0,          32'hFFFFFFFF,   1'b0, 33);
        issue("remu_by0",   ALU_REMU,  32'd100,        32'd0,          32'd100,        1'b0, 33);
        issue("illegal_c",  4'hC,      32'd9,          32'd9,          32'd0,          1'b1, 1);
        drain();

        // Held result: consumer stalls, a competing request must not disturb it.
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue("illegal_f",  ALU_INVALID, 32'd7,        32'd8,          32'd0,          1'b1, 1);
        in_valid = 1'b1;
        alu_op   = ALU_ADD;
        op_a     = 32'd1;
        op_b     = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_result", result, 32'd0);
            chk("hold_illegal", 32'(illegal), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        drain();

        // Reset in the middle of a divide discards it.
        issue("divu_abort", ALU_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_result", result, 32'd0);
        chk("abort_illegal", 32'(illegal), 32'd0);
        q.delete();
        seen = 1'b0;
        in_valid = 1'b1;
        alu_op   = ALU_ADD;
        op_a     = 32'd2;
        op_b     = 32'd3;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        begin
            exp_t e;
            e.name = "add_after_rst";
            e.res  = 32'd5;
            e.z    = 1'b0;
            e.il   = 1'b0;
            e.lat  = 1;
            e.acc  = cyc;
            q.push_back(e);
        end
        in_valid = 1'b0;
        op_a     = 32'd100;
        op_b     = 32'd200;
        drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
